// File: rtl/biu_prefetch_seq_if.sv
// biu_prefetch_seq_if
//   Bundles the multiplexed bus, prefetch-queue and flush signals of the
//   fetch sequencer.
//   master : the sequencer side (drives bus strobes, queue write, fetch_ip)
//   slave  : the environment side (execution unit, queue, memory)
//   Optional macro READY_TIMEOUT_EN adds the bus_err signal.
interface biu_prefetch_seq_if #(
  parameter int ADDR_W = 20
);
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic [2:0]        q_free;
  logic              ready;
  logic [15:0]       ad_in;
  logic [15:0]       ad_out;
  logic              ad_oe;
  logic [ADDR_W-17:0] addr_hi;
  logic              ale;
  logic              rd_n;
  logic              q_wr;
  logic [15:0]       q_data;
  logic [1:0]        q_bytes;
  logic [ADDR_W-1:0] fetch_ip;
  logic              busy;
`ifdef READY_TIMEOUT_EN
  logic              bus_err;
`endif

  modport master (
    input  flush, flush_addr, q_free, ready, ad_in,
    output ad_out, ad_oe, addr_hi, ale, rd_n, q_wr, q_data, q_bytes,
           fetch_ip, busy
`ifdef READY_TIMEOUT_EN
    , output bus_err
`endif
  );

  modport slave (
    output flush, flush_addr, q_free, ready, ad_in,
    input  ad_out, ad_oe, addr_hi, ale, rd_n, q_wr, q_data, q_bytes,
           fetch_ip, busy
`ifdef READY_TIMEOUT_EN
    , input bus_err
`endif
  );
endinterface

// File: rtl/biu_prefetch_seq.sv
// biu_prefetch_seq
//   Bus-interface fetch sequencer feeding the 6-byte prefetch queue. Runs
//   T1..T4 read cycles on the multiplexed bus, pushes code bytes/words into
//   the queue and tracks the prefetch instruction pointer. A flush reloads
//   the pointer and throws away data of the cycle in flight.
//
//   Ports:
//     i_clk   : system clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : biu_prefetch_seq_if.master (flush, queue, bus and status)
//
//   Optional macro READY_TIMEOUT_EN: limits wait states to MAX_WAIT and
//   reports an abandoned cycle on bus_err.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no bus cycle; waits for queue room and no flush
//   T1    | address phase, ale high, address driven on ad_out
//   T2    | bus turnaround, rd_n asserted
//   T3    | data phase, ready sampled
//   TW    | wait state, ready sampled each cycle
//   T4    | end of cycle, queue write (unless discarded)
module biu_prefetch_seq #(
  parameter int                ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 20'hFFFF0,
  parameter int                MAX_WAIT   = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  biu_prefetch_seq_if.master  bus
);

  // The wait counter is 4 bits wide, so the limit must fit in it.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_ip;
  logic              r_discard;
  logic [15:0]       r_data;
  logic              r_ale;
  logic              r_rd_n;
  logic              r_ad_oe;
  logic [15:0]       r_ad_out;
  logic [ADDR_W-17:0] r_addr_hi;
  logic              r_busy;

  state_t            w_state_nxt;
  logic [2:0]        w_need;
  logic [ADDR_W-1:0] w_ip_step;
  logic [ADDR_W-1:0] w_ip_nxt;
  logic              w_q_wr;
  logic              w_capture;

`ifdef READY_TIMEOUT_EN
  logic [3:0]        r_wait_cnt;
  logic              r_bus_err;
  logic              w_timeout;
`endif

  // An odd pointer can only fetch the upper byte of its aligned word.
  assign w_need    = r_fetch_ip[0] ? 3'd1 : 3'd2;
  assign w_ip_step = {{(ADDR_W-3){1'b0}}, w_need};

`ifdef READY_TIMEOUT_EN
  // A timed-out cycle reaches T4 but its data is never valid.
  assign w_q_wr = (r_state == S_T4) && !r_discard && !bus.flush && !r_bus_err;
`else
  assign w_q_wr = (r_state == S_T4) && !r_discard && !bus.flush;
`endif

  assign w_capture = ((r_state == S_T3) || (r_state == S_TW)) && bus.ready;

  // Flush wins over the post-write increment; the add wraps at 2^ADDR_W.
  always_comb begin
    w_ip_nxt = r_fetch_ip;
    if (bus.flush) begin
      w_ip_nxt = bus.flush_addr;
    end else if (w_q_wr) begin
      w_ip_nxt = r_fetch_ip + w_ip_step;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef READY_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && (bus.q_free >= w_need)) begin
          w_state_nxt = S_T1;
        end
      end
      S_T1: w_state_nxt = S_T2;
      S_T2: w_state_nxt = S_T3;
      S_T3: w_state_nxt = bus.ready ? S_T4 : S_TW;
      S_TW: begin
        if (bus.ready) begin
          w_state_nxt = S_T4;
        end
`ifdef READY_TIMEOUT_EN
        else if (r_wait_cnt == 4'(MAX_WAIT - 1)) begin
          w_state_nxt = S_T4;
          w_timeout   = 1'b1;
        end
`endif
      end
      S_T4: begin
        // Room check uses the queue level before this write lands.
        if (!bus.flush && (bus.q_free >= (w_need + 3'd2))) begin
          w_state_nxt = S_T1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they are glitch-free
  // and line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_ip <= RESET_ADDR;
      r_discard  <= 1'b0;
      r_data     <= 16'h0000;
      r_ale      <= 1'b0;
      r_rd_n     <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_ad_out   <= 16'h0000;
      r_addr_hi  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_ip <= w_ip_nxt;

      if (r_state == S_T4) begin
        r_discard <= 1'b0;
      end else if (bus.flush && (r_state != S_IDLE)) begin
        r_discard <= 1'b1;
      end

      if (w_capture) begin
        r_data <= bus.ad_in;
      end

      r_ale   <= (w_state_nxt == S_T1);
      r_ad_oe <= (w_state_nxt == S_T1);
      r_rd_n  <= !((w_state_nxt == S_T2) || (w_state_nxt == S_T3) ||
                   (w_state_nxt == S_TW));
      r_busy  <= (w_state_nxt != S_IDLE);

      if (w_state_nxt == S_T1) begin
        r_ad_out  <= {w_ip_nxt[15:1], 1'b0};
        r_addr_hi <= w_ip_nxt[ADDR_W-1:16];
      end else begin
        r_ad_out  <= 16'h0000;
        r_addr_hi <= '0;
      end
    end
  end

`ifdef READY_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 4'd0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_state_nxt == S_T1) begin
        r_wait_cnt <= 4'd0;
      end else if (r_state == S_TW) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      r_bus_err <= w_timeout;
    end
  end

  assign bus.bus_err = r_bus_err;
`endif

  assign bus.q_wr     = w_q_wr;
  assign bus.q_bytes  = (r_state == S_T4) ? (r_fetch_ip[0] ? 2'd1 : 2'd2) : 2'd0;
  assign bus.q_data   = (r_state != S_T4) ? 16'h0000 :
                        r_fetch_ip[0]     ? {8'h00, r_data[15:8]} : r_data;
  assign bus.ad_out   = r_ad_out;
  assign bus.ad_oe    = r_ad_oe;
  assign bus.addr_hi  = r_addr_hi;
  assign bus.ale      = r_ale;
  assign bus.rd_n     = r_rd_n;
  assign bus.fetch_ip = r_fetch_ip;
  assign bus.busy     = r_busy;

endmodule

// File: doc/biu_prefetch_seq.md
Name: biu_prefetch_seq

Overview:
Bus-interface fetch sequencer that sits directly upstream of the 6-byte prefetch queue.
- Runs T1–T4 read cycles on the multiplexed address/data bus and pushes fetched code words into the queue.
- Tracks the prefetch instruction pointer and issues a cycle only when the queue has room.
- On a flush (jump/branch from the execution unit), discards any in-flight data and restarts fetching at a new address.

Parameters:
ADDR_W, 20, physical address width; upper ADDR_W-16 bits go out on addr_hi
RESET_ADDR, 20'hFFFF0, fetch_ip value after reset
MAX_WAIT, 15, wait-state limit (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  load flush_addr into fetch_ip and discard in-flight data
flush_addr  in  ADDR_W  new fetch address
q_free  in  3  free bytes in prefetch queue (0..6)
ready  in  1  memory ready, sampled in T3/TW
ad_in  in  16  bus data input
ad_out  out  16  bus address output during T1
ad_oe  out  1  bus output enable (1 = drive ad_out)
addr_hi  out  ADDR_W-16  upper address bits, valid in T1
ale  out  1  address latch enable
rd_n  out  1  read strobe, active low
q_wr  out  1  queue write strobe
q_data  out  16  word to queue; single byte is in [7:0]
q_bytes  out  2  number of valid bytes on q_wr (1 or 2)
fetch_ip  out  ADDR_W  next fetch address
busy  out  1  high in any state other than IDLE

Behaviour:
- All transitions are on the rising clk edge. The state register and fetch_ip reset asynchronously on rst_n low.
- Reset values:
  - state = IDLE; fetch_ip = RESET_ADDR; discard = 0.
  - ale = 0, rd_n = 1, ad_oe = 0, q_wr = 0, busy = 0.
  - ad_out = 0, addr_hi = 0, q_bytes = 0.
- need = 1 if fetch_ip[0] = 1, else 2.
- States:
  - IDLE: go to T1 when q_free >= need and flush = 0.
  - T1: ale = 1, ad_oe = 1, ad_out = {fetch_ip[15:1], 1'b0}, addr_hi = fetch_ip[ADDR_W-1:16].
  - T2: ale = 0, ad_oe = 0 (turnaround), rd_n = 0.
  - T3: rd_n = 0. If ready = 1, capture ad_in into the data register and go to T4; otherwise go to TW.
  - TW: rd_n = 0. Stay while ready = 0; when ready = 1, capture ad_in and go to T4.
  - T4: rd_n = 1.
- q_wr is combinational: q_wr = (state == T4) && !discard && !flush.
- Odd fetch_ip:
  - q_bytes = 1; q_data[7:0] = captured[15:8], q_data[15:8] = 0; fetch_ip += 1 on q_wr.
- Even fetch_ip:
  - q_bytes = 2; q_data = captured word (low byte at the lower address); fetch_ip += 2 on q_wr.
- fetch_ip increments modulo 2^ADDR_W; wrap from all-ones to 0 is required.
- Leaving T4:
  - Go directly to T1 (back-to-back cycle) if no flush and q_free >= q_bytes + 2.
  - Otherwise go to IDLE. The comparison uses q_free as sampled this cycle, before the queue write takes effect.
- Zero-wait latency: IDLE with room → T1 next cycle; q_wr is asserted in the 4th cycle after T1 entry (T1, T2, T3, T4).
- flush (priority over all increments):
  - In IDLE: fetch_ip <= flush_addr; stay in IDLE that cycle.
  - In T1/T2/T3/TW: fetch_ip <= flush_addr; discard <= 1. The bus cycle completes normally with full protocol; q_wr is suppressed in T4.
  - In T4: q_wr is suppressed in the same cycle; fetch_ip <= flush_addr; next state IDLE.
- discard clears on leaving T4. A flush_addr arriving later overrides an earlier one.
- Reset mid-cycle aborts immediately to the reset values; no partial queue write occurs.
- Every wait state holds the TW outputs unchanged; rd_n stays low.

Optional Feature:
READY_TIMEOUT_EN
- Defined:
  - A 4-bit counter increments in each TW cycle.
  - If ready is still 0 after MAX_WAIT wait states, the cycle is forced to T4 with q_wr suppressed, fetch_ip is unchanged, and bus_err (extra output, 1 bit, reset 0) pulses high for one clock in that T4.
  - The counter clears on entry to T1.
- Undefined:
  - No counter and no bus_err port; TW waits indefinitely.

Test Plan:
- Reset, q_free = 6, ready = 1, memory returns 16'hB8EA at FFFF0 → T1 ad_out = 16'hFFF0, addr_hi = 4'hF; q_wr in the 4th cycle with q_data = 16'hB8EA, q_bytes = 2; fetch_ip = FFFF2.
- Continuous q_free = 6 → back-to-back cycles; q_wr every 4 clocks; fetch_ip FFFF2, FFFF4, … then FFFFE → 00000 wrap.
- flush to 0x01235 from IDLE, memory word at 0x01234 = 16'h1234 → ad_out = 16'h1234; q_bytes = 1, q_data = 16'h0012; fetch_ip = 01236; next cycle is a 2-byte fetch.
- flush asserted in T2 with flush_addr = 0x00400 → the bus cycle completes; no q_wr in that T4; next T1 drives ad_out = 16'h0400.
- ready held low for 3 cycles in T3 → 3 TW cycles with rd_n low; q_wr one cycle after ready rises; q_free = 1 on an even address → stays in IDLE; busy = 0.
- rst_n pulsed low in TW → outputs return to reset values asynchronously; no q_wr. With READY_TIMEOUT_EN and ready stuck low → bus_err pulses after 15 TW cycles; fetch_ip unchanged.
